// File: rtl/biriscv_bpred_pkg.sv
// Shared types and constants for the biriscv branch predictor.
// The optional gshare history feature is selected by the BPRED_GSHARE_EN macro.
package biriscv_bpred_pkg;

    // Control-flow class recorded in each BTB entry
    typedef enum logic [1:0] {
        BTB_COND = 2'd0,
        BTB_JMP  = 2'd1,
        BTB_CALL = 2'd2,
        BTB_RET  = 2'd3
    } btb_type_e;

    typedef struct packed {
        logic      valid;
        logic [29:0] tag;     // pc[31:2] of the control-flow instruction
        logic [31:0] target;
        btb_type_e kind;
    } btb_entry_t;

    localparam logic [1:0] BHT_RESET        = 2'b01;
    localparam logic [1:0] BHT_TAKEN_THRESH = 2'd2;
    localparam logic [1:0] BHT_MAX          = 2'd3;

    // Saturating 2-bit counter step
    function automatic logic [1:0] bht_step(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == BHT_MAX) ? cnt : cnt + 2'd1;
        else
            return (cnt == 2'd0) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/biriscv_ras.sv
// Circular return address stack; push on full overwrites the oldest entry,
// pop on empty simply wraps the pointer and exposes stale contents.
module biriscv_ras
    import biriscv_bpred_pkg::*;
#(
    parameter int NUM_RAS_ENTRIES = 8
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top
);

    localparam int PW = (NUM_RAS_ENTRIES > 1) ? $clog2(NUM_RAS_ENTRIES) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] top_idx;
    logic [31:0]   stack [NUM_RAS_ENTRIES];

    // ptr names the next free slot, so the most recent push sits one below it
    assign top_idx = ptr - PW'(1);
    assign top     = stack[top_idx];

    // Stack storage and pointer; push wins over pop (they never coincide)
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            // NOTE: this storage is cleared on reset because predictions read it
            // straight after reset; a plain RAM without reset would be preferred otherwise.
            for (int i = 0; i < NUM_RAS_ENTRIES; i++)
                stack[i] <= '0;
        end else if (push) begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            stack[ptr] <= push_data;
            ptr        <= ptr + PW'(1);
        end else if (pop) begin
            ptr <= ptr - PW'(1);
        end
    end

endmodule

// File: rtl/biriscv_bpred.sv
// Fetch-stage branch predictor: fully associative BTB, 2-bit BHT and RAS,
// trained from resolved branches. Define BPRED_GSHARE_EN to XOR a global
// history register into the BHT index.
module biriscv_bpred
    import biriscv_bpred_pkg::*;
#(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_BHT_ENTRIES = 512,
    parameter int NUM_RAS_ENTRIES = 8
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        branch_request_i,
    input  logic        branch_is_taken_i,
    input  logic        branch_is_not_taken_i,
    input  logic [31:0] branch_source_i,
    input  logic [31:0] branch_pc_i,
    input  logic        branch_is_call_i,
    input  logic        branch_is_ret_i,
    input  logic        branch_is_jmp_i,
    input  logic [31:0] pc_f_i,
    output logic [31:0] next_pc_f_o,
    output logic        next_taken_f_o,
    output logic        btb_hit_f_o
);

    localparam int BTB_W = $clog2(NUM_BTB_ENTRIES);
    localparam int BHT_W = $clog2(NUM_BHT_ENTRIES);

    btb_entry_t       btb [NUM_BTB_ENTRIES];
    logic [1:0]       bht [NUM_BHT_ENTRIES];
    logic [BTB_W-1:0] alloc_ptr;

    logic [BHT_W-1:0] lookup_idx;
    logic [BHT_W-1:0] update_idx;
    logic [31:0]      ras_top;

    // Taken wins when both resolution flags are set
    logic upd_taken;
    logic upd_not_taken;
    logic upd_is_cond;
    btb_type_e upd_kind;

    assign upd_taken     = branch_request_i & branch_is_taken_i;
    assign upd_not_taken = branch_request_i & ~branch_is_taken_i & branch_is_not_taken_i;
    assign upd_is_cond   = ~(branch_is_call_i | branch_is_ret_i | branch_is_jmp_i);
    assign upd_kind      = branch_is_call_i ? BTB_CALL :
                           branch_is_ret_i  ? BTB_RET  :
                           branch_is_jmp_i  ? BTB_JMP  : BTB_COND;

`ifdef BPRED_GSHARE_EN
    logic [BHT_W-1:0] ghr;

    assign lookup_idx = pc_f_i[BHT_W+1:2] ^ ghr;
    assign update_idx = branch_source_i[BHT_W+1:2] ^ ghr;

    // Global history of resolved conditional outcomes, newest in bit 0
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)
            ghr <= '0;
        else if (branch_request_i && upd_is_cond)
            ghr <= {ghr[BHT_W-2:0], branch_is_taken_i};
    end
`else
    assign lookup_idx = pc_f_i[BHT_W+1:2];
    assign update_idx = branch_source_i[BHT_W+1:2];
`endif

    // Fetch-side lookup: at most one entry can match
    logic       hit;
    btb_entry_t hit_entry;

    always_comb begin
        // NOTE: defaults first so no path through the loop leaves a latch.
        hit       = 1'b0;
        hit_entry = '0;
        for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
            if (btb[i].valid && btb[i].tag == pc_f_i[31:2]) begin
                hit       = 1'b1;
                hit_entry = btb[i];
            end
        end
    end

    // Update-side lookup on the resolved branch source
    logic             upd_hit;
    logic [BTB_W-1:0] upd_slot;

    always_comb begin
        upd_hit  = 1'b0;
        upd_slot = '0;
        for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
            if (btb[i].valid && btb[i].tag == branch_source_i[31:2]) begin
                upd_hit  = 1'b1;
                upd_slot = i[BTB_W-1:0];
            end
        end
    end

    // Next-PC selection from BTB type, BHT direction and RAS
    always_comb begin
        next_pc_f_o    = pc_f_i + 32'd4;
        next_taken_f_o = 1'b0;
        if (hit) begin
            unique case (hit_entry.kind)
                BTB_RET: begin
                    next_pc_f_o    = ras_top;
                    next_taken_f_o = 1'b1;
                end
                BTB_JMP, BTB_CALL: begin
                    next_pc_f_o    = hit_entry.target;
                    next_taken_f_o = 1'b1;
                end
                default: begin
                    if (bht[lookup_idx] >= BHT_TAKEN_THRESH) begin
                        next_pc_f_o    = hit_entry.target;
                        next_taken_f_o = 1'b1;
                    end
                end
            endcase
        end
    end

    assign btb_hit_f_o = hit;

    // BTB training: refresh on hit, round-robin allocate on miss, taken only
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr <= '0;
            for (int i = 0; i < NUM_BTB_ENTRIES; i++)
                btb[i] <= '0;
        end else if (upd_taken) begin
            if (upd_hit) begin
                btb[upd_slot].target <= branch_pc_i;
                btb[upd_slot].kind   <= upd_kind;
            end else begin
                btb[alloc_ptr] <= '{valid: 1'b1, tag: branch_source_i[31:2],
                                    target: branch_pc_i, kind: upd_kind};
                alloc_ptr      <= alloc_ptr + BTB_W'(1);
            end
        end
    end

    // BHT training on every resolved request
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BHT_ENTRIES; i++)
                bht[i] <= BHT_RESET;
        end else if (upd_taken || upd_not_taken) begin
            bht[update_idx] <= bht_step(bht[update_idx], upd_taken);
        end
    end

    biriscv_ras #(
        .NUM_RAS_ENTRIES(NUM_RAS_ENTRIES)
    ) u_ras (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .push      (branch_request_i & branch_is_call_i),
        .pop       (branch_request_i & branch_is_ret_i),
        .push_data (branch_source_i + 32'd4),
        .top       (ras_top)
    );

endmodule

// File: tb/tb_biriscv_bpred.sv
// Directed self-checking bench for biriscv_bpred with a small scoreboard queue.
// Conditional-counter checks assume the default build; the gshare pattern
// check runs only when BPRED_GSHARE_EN is defined.
module tb_biriscv_bpred;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        branch_request_i;
    logic        branch_is_taken_i;
    logic        branch_is_not_taken_i;
    logic [31:0] branch_source_i;
    logic [31:0] branch_pc_i;
    logic        branch_is_call_i;
    logic        branch_is_ret_i;
    logic        branch_is_jmp_i;
    logic [31:0] pc_f_i;
    logic [31:0] next_pc_f_o;
    logic        next_taken_f_o;
    logic        btb_hit_f_o;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic        hit;
    } exp_t;

    exp_t sb [$];

    always #5 clk_i = ~clk_i;

    biriscv_bpred dut (
        .clk_i                 (clk_i),
        .rst_n                 (rst_n),
        .branch_request_i      (branch_request_i),
        .branch_is_taken_i     (branch_is_taken_i),
        .branch_is_not_taken_i (branch_is_not_taken_i),
        .branch_source_i       (branch_source_i),
        .branch_pc_i           (branch_pc_i),
        .branch_is_call_i      (branch_is_call_i),
        .branch_is_ret_i       (branch_is_ret_i),
        .branch_is_jmp_i       (branch_is_jmp_i),
        .pc_f_i                (pc_f_i),
        .next_pc_f_o           (next_pc_f_o),
        .next_taken_f_o        (next_taken_f_o),
        .btb_hit_f_o           (btb_hit_f_o)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive a fetch PC now, push the expectation, sample 1ns later
    task automatic predict_now(input logic [31:0] pc, input logic [31:0] exp_pc,
                               input logic exp_taken, input logic exp_hit, input string tag);
        exp_t e;
        pc_f_i = pc;
        sb.push_back('{pc: exp_pc, taken: exp_taken, hit: exp_hit});
        #1;
        e = sb.pop_front();
        cmp({tag, ".pc"},    next_pc_f_o,           e.pc);
        cmp({tag, ".taken"}, {31'd0, next_taken_f_o}, {31'd0, e.taken});
        cmp({tag, ".hit"},   {31'd0, btb_hit_f_o},    {31'd0, e.hit});
    endtask

    task automatic predict(input logic [31:0] pc, input logic [31:0] exp_pc,
                           input logic exp_taken, input logic exp_hit, input string tag);
        @(negedge clk_i);
        predict_now(pc, exp_pc, exp_taken, exp_hit, tag);
    endtask

    task automatic clear_req();
        branch_request_i      = 1'b0;
        branch_is_taken_i     = 1'b0;
        branch_is_not_taken_i = 1'b0;
        branch_is_call_i      = 1'b0;
        branch_is_ret_i       = 1'b0;
        branch_is_jmp_i       = 1'b0;
        branch_source_i       = '0;
        branch_pc_i           = '0;
    endtask

    // kind: 0 cond, 1 jmp, 2 call, 3 ret
    task automatic drive_req(input logic [31:0] src, input logic [31:0] tgt,
                             input logic t, input logic nt, input int kind);
        @(negedge clk_i);
        branch_request_i      = 1'b1;
        branch_is_taken_i     = t;
        branch_is_not_taken_i = nt;
        branch_source_i       = src;
        branch_pc_i           = tgt;
        branch_is_jmp_i       = (kind == 1);
        branch_is_call_i      = (kind == 2);
        branch_is_ret_i       = (kind == 3);
    endtask

    task automatic end_req();
        @(posedge clk_i);
        #1;
        clear_req();
    endtask

    task automatic resolve(input logic [31:0] src, input logic [31:0] tgt,
                           input logic t, input logic nt, input int kind);
        drive_req(src, tgt, t, nt, kind);
        end_req();
    endtask

    task automatic do_reset();
        clear_req();
        @(negedge clk_i);
        rst_n = 1'b0;
        #3;
        @(negedge clk_i);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        pc_f_i = 32'h1000;
        clear_req();

        // Outputs while reset is held
        #2;
        predict_now(32'h1000, 32'h1004, 1'b0, 1'b0, "in_reset");
        do_reset();

        predict(32'h1000, 32'h1004, 1'b0, 1'b0, "post_reset");

        // Jump training; same-cycle lookup still sees the old (empty) entry
        drive_req(32'h1000, 32'h2000, 1'b1, 1'b0, 1);
        predict_now(32'h1000, 32'h1004, 1'b0, 1'b0, "jmp_same_cycle");
        end_req();
        predict(32'h1000, 32'h2000, 1'b1, 1'b1, "jmp_hit");

        // pc+4 wraps at the top of the address space
        predict(32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, "pc_wrap");

`ifndef BPRED_GSHARE_EN
        // Conditional counter saturation at one PC
        do_reset();
        resolve(32'h3000, 32'h3400, 1'b1, 1'b0, 0);   // 01 -> 10
        resolve(32'h3000, 32'h3400, 1'b1, 1'b0, 0);   // 10 -> 11
        predict(32'h3000, 32'h3400, 1'b1, 1'b1, "cond_tt");
        resolve(32'h3000, 32'h3400, 1'b1, 1'b0, 0);   // stays 11
        resolve(32'h3000, 32'h3400, 1'b0, 1'b1, 0);   // 11 -> 10
        predict(32'h3000, 32'h3400, 1'b1, 1'b1, "cond_sat_hi");
        resolve(32'h3000, 32'h3400, 1'b0, 1'b1, 0);   // 10 -> 01
        predict(32'h3000, 32'h3004, 1'b0, 1'b1, "cond_n2");
        resolve(32'h3000, 32'h3400, 1'b0, 1'b1, 0);   // 01 -> 00
        predict(32'h3000, 32'h3004, 1'b0, 1'b1, "cond_n3");
        resolve(32'h3000, 32'h3400, 1'b1, 1'b0, 0);   // 00 -> 01
        predict(32'h3000, 32'h3004, 1'b0, 1'b1, "cond_sat_lo");

        // Both resolution flags set counts as taken
        resolve(32'h3804, 32'h3900, 1'b1, 1'b1, 0);   // 01 -> 10, allocates
        predict(32'h3804, 32'h3900, 1'b1, 1'b1, "cond_both");
`endif

        // Not-taken miss never allocates
        resolve(32'h3C08, 32'h3D00, 1'b0, 1'b1, 0);
        predict(32'h3C08, 32'h3C0C, 1'b0, 1'b0, "nt_no_alloc");

        // Return address stack
        do_reset();
        resolve(32'h4000, 32'h9000, 1'b1, 1'b0, 2);   // push 0x4004
        resolve(32'h5000, 32'h4004, 1'b1, 1'b0, 3);   // pop
        predict(32'h4000, 32'h9000, 1'b1, 1'b1, "call_target");
        resolve(32'h4000, 32'h9000, 1'b1, 1'b0, 2);   // push 0x4004 again
        predict(32'h5000, 32'h4004, 1'b1, 1'b1, "ret_pred");
        for (int k = 0; k < 9; k++)
            resolve(32'h6000 + 32'(k) * 32'h10, 32'h9000, 1'b1, 1'b0, 2);
        predict(32'h5000, 32'h6084, 1'b1, 1'b1, "ras_overflow_top");
        resolve(32'h5000, 32'h6084, 1'b1, 1'b0, 3);
        predict(32'h5000, 32'h6074, 1'b1, 1'b1, "ras_after_pop");

        // Round-robin eviction after 33 allocations
        do_reset();
        for (int k = 0; k < 33; k++)
            resolve(32'h10000 + 32'(k) * 32'h4, 32'h20000 + 32'(k) * 32'h8, 1'b1, 1'b0, 1);
        predict(32'h10000, 32'h10004, 1'b0, 1'b0, "evicted_first");
        predict(32'h10080, 32'h20100, 1'b1, 1'b1, "hit_33rd");
        // Hit refresh must not move the allocation pointer
        resolve(32'h10004, 32'h30000, 1'b1, 1'b0, 1);
        predict(32'h10004, 32'h30000, 1'b1, 1'b1, "hit_refresh");
        resolve(32'h50000, 32'h51000, 1'b1, 1'b0, 1);
        predict(32'h50000, 32'h51000, 1'b1, 1'b1, "alloc_after_refresh");
        predict(32'h10004, 32'h10008, 1'b0, 1'b0, "slot1_replaced");
        predict(32'h10008, 32'h20010, 1'b1, 1'b1, "slot2_kept");

        // Reset asserted while an update is on the bus
        drive_req(32'h7000, 32'h7800, 1'b1, 1'b0, 1);
        #2;
        rst_n = 1'b0;
        end_req();
        @(negedge clk_i);
        rst_n = 1'b1;
        predict(32'h7000, 32'h7004, 1'b0, 1'b0, "rst_discard");
        predict(32'h10080, 32'h10084, 1'b0, 1'b0, "rst_cleared");

`ifdef BPRED_GSHARE_EN
        // Alternating T/N at one PC becomes predictable with history
        do_reset();
        for (int k = 0; k < 24; k++)
            resolve(32'h8000, 32'h8400, (k % 2) == 0, (k % 2) != 0, 0);
        predict(32'h8000, 32'h8400, 1'b1, 1'b1, "gshare_t");
        resolve(32'h8000, 32'h8400, 1'b1, 1'b0, 0);
        predict(32'h8000, 32'h8004, 1'b0, 1'b1, "gshare_n");
        resolve(32'h8000, 32'h8400, 1'b0, 1'b1, 0);
        predict(32'h8000, 32'h8400, 1'b1, 1'b1, "gshare_t2");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
